// File: rtl/letc_core_pkg.sv
// rtl/letc_core_pkg.sv - shared types and helpers for the LETC core fetch stage
// Contents: pc_t/word_t, f2d_s decode payload, fetch_state_e, PC_STEP, word_align().
package letc_core_pkg;

   typedef logic [31:0] pc_t;
   typedef logic [31:0] word_t;

   // One fetched instruction as handed to decode.
   typedef struct packed {
      pc_t   pc;
      word_t instr;
      logic  fault;
   } f2d_s;

   typedef enum logic [0:0] {
      RUN  = 1'b0,
      HALT = 1'b1
   } fetch_state_e;

   localparam pc_t PC_STEP = 32'd4;

   function automatic pc_t word_align(input pc_t pc);
      return pc & ~32'd3;
   endfunction

endpackage

// File: rtl/letc_core_fetch_fifo.sv
// rtl/letc_core_fetch_fifo.sv - small synchronous FIFO with flush and fill count
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_push, i_data   write one entry
//   i_pop            drop the head entry (ignored when empty)
//   i_flush          empty the FIFO; overrides push and pop
//   o_data           head entry (storage resets to zero)
//   o_count          number of valid entries, 0..DEPTH
module letc_core_fetch_fifo #(
   parameter int  DEPTH = 2,
   parameter type T     = logic [31:0]
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic                         i_push,
   input  T                             i_data,
   input  logic                         i_pop,
   input  logic                         i_flush,
   output T                             o_data,
   output logic [$clog2(DEPTH+1)-1:0]   o_count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   T              mem_q [DEPTH];
   T              mem_d [DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_pop;

   // Pointers wrap explicitly so non-power-of-two depths work.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      do_pop   = i_pop && (count_q != '0);
      if (i_flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (i_push) begin
            mem_d[wr_ptr_q] = i_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
         end
         if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
         count_d = count_q + CW'(i_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Callers size their credits so that neither of these can happen.
   always_ff @(posedge i_clk) begin
      if (i_rst_n && !i_flush) begin
         assert (!(i_push && !i_pop && (count_q == CW'(DEPTH))));
         assert (!(i_pop && (count_q == '0)));
      end
   end

   assign o_data  = mem_q[rd_ptr_q];
   assign o_count = count_q;

endmodule

// File: rtl/letc_core_stage_f.sv
// rtl/letc_core_stage_f.sv - LETC instruction fetch stage (PC, imem requests, fetch queue)
// Ports:
//   i_clk, i_rst_n                     clock, asynchronous active-low reset
//   o_imem_req_valid/i_imem_req_ready  fetch request handshake, o_imem_req_addr = PC
//   i_imem_rsp_valid/_data/_fault      in-order, non-stallable instruction responses
//   i_redirect_valid/i_redirect_pc     single-cycle redirect from a later stage
//   o_f2d_valid/i_f2d_ready            decode handshake; o_f2d_pc/_instr/_fault = queue head
module letc_core_stage_f
   import letc_core_pkg::*;
#(
   parameter pc_t RESET_PC    = 32'h0000_0000,
   parameter int  QUEUE_DEPTH = 2
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   output logic        o_imem_req_valid,
   input  logic        i_imem_req_ready,
   output logic [31:0] o_imem_req_addr,
   input  logic        i_imem_rsp_valid,
   input  logic [31:0] i_imem_rsp_data,
   input  logic        i_imem_rsp_fault,
   input  logic        i_redirect_valid,
   input  logic [31:0] i_redirect_pc,
   output logic        o_f2d_valid,
   input  logic        i_f2d_ready,
   output logic [31:0] o_f2d_pc,
   output logic [31:0] o_f2d_instr,
   output logic        o_f2d_fault
);

   localparam int           CW      = $clog2(QUEUE_DEPTH + 1);
   localparam logic [CW:0]  DEPTH_W = (CW + 1)'(QUEUE_DEPTH);

   pc_t           pc_q, pc_d;
   logic [CW-1:0] discard_q, discard_d;
   fetch_state_e  state_q, state_d;
   logic          req_en_q;

   logic [CW-1:0] out_count;
   logic [CW-1:0] q_count;
   logic [CW-1:0] out_next;
   logic [CW:0]   credit_used;
   pc_t           rsp_pc;
   f2d_s          q_head;
   f2d_s          q_wdata;
   logic          req_fire;
   logic          rsp_keep;
   logic          q_pop;

   // Request side: in-flight fetches plus queued entries may never exceed the
   // queue depth, so every response always has a slot waiting for it.
   // req_en_q keeps the request valid low while reset is held.
   always_comb begin
      credit_used      = {1'b0, out_count} + {1'b0, q_count};
      o_imem_req_valid = req_en_q && (state_q == RUN) && (credit_used < DEPTH_W);
      o_imem_req_addr  = pc_q;
      req_fire         = o_imem_req_valid && i_imem_req_ready;
   end

   // Response side: responses belonging to squashed requests are dropped
   // while discard is non-zero; a response landing in a redirect cycle is
   // dropped as well because the flush wins.
   always_comb begin
      rsp_keep = i_imem_rsp_valid && (discard_q == '0) && !i_redirect_valid;
      q_wdata  = '{pc: rsp_pc, instr: i_imem_rsp_data, fault: i_imem_rsp_fault};
      q_pop    = o_f2d_valid && i_f2d_ready;
      out_next = out_count + CW'(req_fire) - CW'(i_imem_rsp_valid);
   end

   always_comb begin
      pc_d      = pc_q;
      discard_d = discard_q;
      state_d   = state_q;
      if (req_fire) begin
         pc_d = pc_q + PC_STEP;
      end
      if (i_imem_rsp_valid && (discard_q != '0)) begin
         discard_d = discard_q - CW'(1);
      end
      if (rsp_keep && i_imem_rsp_fault) begin
         state_d = HALT;
      end
      // Everything still in flight after this cycle belongs to the old path.
      if (i_redirect_valid) begin
         pc_d      = word_align(i_redirect_pc);
         discard_d = out_next;
         state_d   = RUN;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pc_q      <= RESET_PC;
         discard_q <= '0;
         state_q   <= RUN;
         req_en_q  <= 1'b0;
      end else begin
         pc_q      <= pc_d;
         discard_q <= discard_d;
         state_q   <= state_d;
         req_en_q  <= 1'b1;
      end
   end

   // PC of every issued request, popped as its response returns.
   letc_core_fetch_fifo #(
      .DEPTH (QUEUE_DEPTH),
      .T     (pc_t)
   ) u_pc_track (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (req_fire),
      .i_data  (pc_q),
      .i_pop   (i_imem_rsp_valid),
      .i_flush (1'b0),
      .o_data  (rsp_pc),
      .o_count (out_count)
   );

   letc_core_fetch_fifo #(
      .DEPTH (QUEUE_DEPTH),
      .T     (f2d_s)
   ) u_fetch_q (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (rsp_keep),
      .i_data  (q_wdata),
      .i_pop   (q_pop),
      .i_flush (i_redirect_valid),
      .o_data  (q_head),
      .o_count (q_count)
   );

   always_comb begin
      o_f2d_valid = (q_count != '0);
      o_f2d_pc    = q_head.pc;
      o_f2d_instr = q_head.instr;
      o_f2d_fault = q_head.fault;
   end

endmodule

// File: tb/tb_letc_core_stage_f.sv
// tb/tb_letc_core_stage_f.sv - self-checking bench for letc_core_stage_f
module tb_letc_core_stage_f;
   import letc_core_pkg::*;

   localparam int          DEPTH = 2;
   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        o_imem_req_valid;
   logic        i_imem_req_ready;
   logic [31:0] o_imem_req_addr;
   logic        i_imem_rsp_valid;
   logic [31:0] i_imem_rsp_data;
   logic        i_imem_rsp_fault;
   logic        i_redirect_valid;
   logic [31:0] i_redirect_pc;
   logic        o_f2d_valid;
   logic        i_f2d_ready;
   logic [31:0] o_f2d_pc;
   logic [31:0] o_f2d_instr;
   logic        o_f2d_fault;

   always #5 clk = ~clk;

   letc_core_stage_f #(
      .RESET_PC    (RST_PC),
      .QUEUE_DEPTH (DEPTH)
   ) dut (
      .i_clk            (clk),
      .i_rst_n          (rst_n),
      .o_imem_req_valid (o_imem_req_valid),
      .i_imem_req_ready (i_imem_req_ready),
      .o_imem_req_addr  (o_imem_req_addr),
      .i_imem_rsp_valid (i_imem_rsp_valid),
      .i_imem_rsp_data  (i_imem_rsp_data),
      .i_imem_rsp_fault (i_imem_rsp_fault),
      .i_redirect_valid (i_redirect_valid),
      .i_redirect_pc    (i_redirect_pc),
      .o_f2d_valid      (o_f2d_valid),
      .i_f2d_ready      (i_f2d_ready),
      .o_f2d_pc         (o_f2d_pc),
      .o_f2d_instr      (o_f2d_instr),
      .o_f2d_fault      (o_f2d_fault)
   );

   // Memory transactions carry the path epoch they were issued on; a redirect
   // starts a new epoch and anything older never reaches decode.
   typedef struct {
      logic [31:0] exp_pc;
      logic [31:0] addr;
      int          epoch;
      int          due;
   } mem_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        fault;
   } item_t;

   mem_t        pend[$];
   item_t       exp_q[$];
   logic [31:0] next_pc;
   int          epoch;
   int          cyc;
   bit          halted;
   bit          fresh;
   logic [31:0] fault_addr = 32'h0000_0001;
   bit          rand_fault = 1'b0;
   int          p_ready = 100;
   int          p_rsp = 100;
   int          p_f2d = 100;
   int          lat_extra = 0;
   int          vectors = 0;
   int          errors = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
   endfunction

   function automatic logic is_fault(input logic [31:0] a);
      logic [31:0] w;
      w = mem_word(a);
      return (a == fault_addr) || (rand_fault && (w[6:0] == 7'd0));
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: check at the negedge, drive, clock, then advance the model.
   task automatic step(input bit redir, input logic [31:0] tgt);
      bit          exp_rv, fire, rsp, f2d_fire;
      logic [31:0] a;
      mem_t        h;
      exp_rv = !fresh && !halted && ((pend.size() + exp_q.size()) < DEPTH);
      chk("req_valid", 32'(o_imem_req_valid), 32'(exp_rv));
      if (exp_rv && o_imem_req_valid) chk("req_addr", o_imem_req_addr, next_pc);
      chk("f2d_valid", 32'(o_f2d_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
         chk("f2d_pc", o_f2d_pc, exp_q[0].pc);
         chk("f2d_instr", o_f2d_instr, exp_q[0].instr);
         chk("f2d_fault", 32'(o_f2d_fault), 32'(exp_q[0].fault));
      end
      i_imem_req_ready = int'($urandom_range(99)) < p_ready;
      rsp = (pend.size() != 0) && (pend[0].due <= cyc) && (int'($urandom_range(99)) < p_rsp);
      i_imem_rsp_valid = rsp;
      i_imem_rsp_data  = rsp ? mem_word(pend[0].addr) : $urandom;
      i_imem_rsp_fault = rsp ? is_fault(pend[0].addr) : 1'b0;
      i_f2d_ready      = int'($urandom_range(99)) < p_f2d;
      i_redirect_valid = redir;
      i_redirect_pc    = tgt;
      fire     = o_imem_req_valid && i_imem_req_ready;
      a        = o_imem_req_addr;
      f2d_fire = (exp_q.size() != 0) && i_f2d_ready;
      @(posedge clk);
      cyc++;
      fresh = 1'b0;
      if (fire) begin
         pend.push_back('{exp_pc: next_pc, addr: a, epoch: epoch,
                          due: cyc + int'($urandom_range(lat_extra))});
         next_pc = next_pc + 32'd4;
      end
      if (f2d_fire && !redir) void'(exp_q.pop_front());
      if (rsp) begin
         h = pend.pop_front();
         if (!redir && (h.epoch == epoch)) begin
            exp_q.push_back('{pc: h.exp_pc, instr: mem_word(h.exp_pc), fault: is_fault(h.exp_pc)});
            if (is_fault(h.exp_pc)) halted = 1'b1;
         end
      end
      if (redir) begin
         exp_q.delete();
         halted  = 1'b0;
         epoch++;
         next_pc = {tgt[31:2], 2'b00};
      end
      @(negedge clk);
   endtask

   task automatic do_reset(input bit immediate);
      rst_n            = 1'b0;
      i_imem_req_ready = 1'b0;
      i_imem_rsp_valid = 1'b0;
      i_imem_rsp_data  = '0;
      i_imem_rsp_fault = 1'b0;
      i_redirect_valid = 1'b0;
      i_redirect_pc    = '0;
      i_f2d_ready      = 1'b0;
      if (immediate) begin
         #1;
         chk("rst_async_f2d_valid", 32'(o_f2d_valid), 32'd0);
         chk("rst_async_req_valid", 32'(o_imem_req_valid), 32'd0);
      end
      @(posedge clk);
      #1;
      chk("rst_req_valid", 32'(o_imem_req_valid), 32'd0);
      chk("rst_f2d_valid", 32'(o_f2d_valid), 32'd0);
      chk("rst_f2d_fault", 32'(o_f2d_fault), 32'd0);
      chk("rst_req_addr", o_imem_req_addr, RST_PC);
      chk("rst_f2d_pc", o_f2d_pc, 32'd0);
      chk("rst_f2d_instr", o_f2d_instr, 32'd0);
      @(negedge clk);
      pend.delete();
      exp_q.delete();
      next_pc = RST_PC;
      halted  = 1'b0;
      fresh   = 1'b1;
      epoch++;
      rst_n   = 1'b1;
   endtask

   // Steps until decode is offered something, then checks and consumes it.
   task automatic expect_next(input string tag, input logic [31:0] pc, input logic flt);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         if (o_f2d_valid) begin
            seen = 1'b1;
            chk({tag, "_pc"}, o_f2d_pc, pc);
            chk({tag, "_fault"}, 32'(o_f2d_fault), 32'(flt));
         end
         step(1'b0, 32'd0);
      end
      chk({tag, "_seen"}, 32'(seen), 32'd1);
   endtask

   task automatic drain();
      p_ready   = 0;
      p_rsp     = 100;
      p_f2d     = 100;
      lat_extra = 0;
      for (int i = 0; i < 30 && ((pend.size() != 0) || (exp_q.size() != 0)); i++) begin
         step(1'b0, 32'd0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed no finish, expected finish before timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      epoch = 0;
      cyc   = 0;
      do_reset(1'b0);

      // streaming with 1-cycle memory and an always-ready decode
      p_ready = 100; p_rsp = 100; p_f2d = 100; lat_extra = 0;
      repeat (20) step(1'b0, 32'd0);

      // decode stalled: the queue fills and requests stop
      p_f2d = 0;
      repeat (10) step(1'b0, 32'd0);
      chk("bp_req_stalled", 32'(o_imem_req_valid), 32'd0);
      chk("bp_q_holding", 32'(o_f2d_valid), 32'd1);
      p_f2d = 100;
      repeat (10) step(1'b0, 32'd0);

      // two fetches in flight, then redirect to an unaligned target
      drain();
      step(1'b1, 32'h10);
      p_ready = 100; p_rsp = 0;
      step(1'b0, 32'd0);
      step(1'b0, 32'd0);
      chk("inflight_no_credit", 32'(o_imem_req_valid), 32'd0);
      step(1'b1, 32'h203);
      p_rsp = 100;
      expect_next("redir_a", 32'h200, 1'b0);
      expect_next("redir_b", 32'h204, 1'b0);

      // faulting fetch halts the stage until a redirect
      drain();
      fault_addr = 32'h8;
      step(1'b1, 32'h0);
      p_ready = 100;
      expect_next("flt_0", 32'h0, 1'b0);
      expect_next("flt_4", 32'h4, 1'b0);
      expect_next("flt_8", 32'h8, 1'b1);
      repeat (8) step(1'b0, 32'd0);
      chk("halt_no_req", 32'(o_imem_req_valid), 32'd0);
      fault_addr = 32'h1;
      step(1'b1, 32'h40);
      expect_next("resume", 32'h40, 1'b0);

      // redirect together with a request handshake and a response
      drain();
      step(1'b1, 32'h100);
      p_ready = 100; p_rsp = 0;
      step(1'b0, 32'd0);
      p_rsp = 100;
      step(1'b1, 32'h300);
      expect_next("coincide", 32'h300, 1'b0);

      // PC wrap at the top of the address space
      drain();
      step(1'b1, 32'hFFFF_FFFC);
      p_ready = 100;
      expect_next("wrap_hi", 32'hFFFF_FFFC, 1'b0);
      expect_next("wrap_lo", 32'h0, 1'b0);

      // randomized traffic, with a reset in the middle
      rand_fault = 1'b1;
      for (int blk = 0; blk < 20; blk++) begin
         p_ready   = int'($urandom_range(100, 20));
         p_rsp     = int'($urandom_range(100, 20));
         p_f2d     = int'($urandom_range(100, 10));
         lat_extra = int'($urandom_range(3));
         for (int i = 0; i < 100; i++) begin
            step($urandom_range(24) == 0, $urandom);
         end
         if (blk == 10) do_reset(1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
